// File: rtl/if_stage.sv
// Instruction fetch stage with IF/ID register; single outstanding imem request,
// skid buffer absorbs a response that lands while decode is stalled.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] id_PC,
  output logic [31:0] id_Inst,
  output logic        id_Valid,
  output logic        if_Busy
);

  typedef enum logic [1:0] {FETCH, WAIT, HOLD, DROP} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] req_pc, req_pc_n;
  logic [31:0] skid_pc, skid_pc_n;
  logic [31:0] skid_inst, skid_inst_n;
  logic [31:0] id_pc_n, id_inst_n;
  logic        id_valid_n;

  assign imem_req  = (state == FETCH) & ~rst;
  assign imem_addr = pc & 32'hFFFF_FFFC;
  assign if_Busy   = ((state == WAIT) | (state == DROP)) & ~rst;

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    req_pc_n    = req_pc;
    skid_pc_n   = skid_pc;
    skid_inst_n = skid_inst;
    id_pc_n     = id_PC;
    id_inst_n   = id_Inst;
    id_valid_n  = id_Valid;

    if (br_taken) begin
      // Redirect wins over stall and any response arriving this cycle.
      pc_n       = br_target & 32'hFFFF_FFFC;
      id_pc_n    = '0;
      id_inst_n  = NOP_INST;
      id_valid_n = 1'b0;
      case (state)
        FETCH:   state_n = DROP;
        WAIT:    state_n = imem_valid ? FETCH : DROP;
        HOLD:    state_n = FETCH;
        DROP:    state_n = imem_valid ? FETCH : DROP;
        default: state_n = FETCH;
      endcase
    end else begin
      case (state)
        FETCH: begin
          state_n  = WAIT;
          req_pc_n = pc;
        end
        WAIT: begin
          if (imem_valid) begin
            if (stall) begin
              skid_pc_n   = req_pc;
              skid_inst_n = imem_rdata;
              state_n     = HOLD;
            end else begin
              id_pc_n    = req_pc;
              id_inst_n  = imem_rdata;
              id_valid_n = 1'b1;
              pc_n       = req_pc + 32'd4;
              state_n    = FETCH;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            id_pc_n    = skid_pc;
            id_inst_n  = skid_inst;
            id_valid_n = 1'b1;
            pc_n       = skid_pc + 32'd4;
            state_n    = FETCH;
          end
        end
        DROP: begin
          // PC already points at the redirect target; just swallow the stale word.
          if (imem_valid) state_n = FETCH;
        end
        default: state_n = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      req_pc    <= '0;
      skid_pc   <= '0;
      skid_inst <= '0;
      id_PC     <= '0;
      id_Inst   <= NOP_INST;
      id_Valid  <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      req_pc    <= req_pc_n;
      skid_pc   <= skid_pc_n;
      skid_inst <= skid_inst_n;
      id_PC     <= id_pc_n;
      id_Inst   <= id_inst_n;
      id_Valid  <= id_valid_n;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: fixed-latency memory model driven from the
// stimulus thread, expected values written out by hand.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst, stall, br_taken;
  logic [31:0] br_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] id_PC, id_Inst;
  logic        id_Valid, if_Busy;

  int n_checks = 0;
  int n_fails  = 0;

  logic        pending = 1'b0;
  int          cnt = 0;
  int          lat = 1;
  logic [31:0] paddr = '0;

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_valid(imem_valid), .id_PC(id_PC), .id_Inst(id_Inst),
    .id_Valid(id_Valid), .if_Busy(if_Busy)
  );

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h00A0_0093;
      32'h0000_0004: return 32'h0010_8113;
      32'h0000_0010: return 32'h1234_5678;
      default:       return {16'hC0DE, a[15:0]};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: sample the request, cross the edge, then advance the memory.
  task automatic tick();
    logic        req_now;
    logic [31:0] addr_now;
    #1;
    req_now  = imem_req;
    addr_now = imem_addr;
    @(posedge clk);
    #1;
    imem_valid = 1'b0;
    if (req_now) begin
      pending = 1'b1;
      cnt     = lat;
      paddr   = addr_now;
    end
    if (pending) begin
      cnt--;
      if (cnt == 0) begin
        imem_valid = 1'b1;
        imem_rdata = mem_data(paddr);
        pending    = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = '0;
    imem_rdata = '0; imem_valid = 1'b0;

    // Reset
    tick(); tick();
    check("rst_req",   {31'd0, imem_req}, 32'd0);
    check("rst_busy",  {31'd0, if_Busy},  32'd0);
    check("rst_valid", {31'd0, id_Valid}, 32'd0);
    check("rst_inst",  id_Inst, 32'h0000_0013);
    check("rst_pc",    id_PC,   32'h0);
    rst = 1'b0;

    // Free-run with 1-cycle memory
    #1;
    check("fr_req0",  {31'd0, imem_req}, 32'd1);
    check("fr_addr0", imem_addr, 32'h0);
    tick();
    check("fr_busy",  {31'd0, if_Busy},  32'd1);
    check("fr_noreq", {31'd0, imem_req}, 32'd0);
    tick();
    check("fr_idpc0",  id_PC,   32'h0);
    check("fr_inst0",  id_Inst, 32'h00A0_0093);
    check("fr_valid0", {31'd0, id_Valid}, 32'd1);
    check("fr_addr4",  imem_addr, 32'h4);
    tick(); tick();
    check("fr_idpc4", id_PC,   32'h4);
    check("fr_inst4", id_Inst, 32'h0010_8113);
    check("fr_addr8", imem_addr, 32'h8);

    // Response for 0x10 lands under stall
    tick(); tick(); tick(); tick();
    check("st_addr10", imem_addr, 32'h10);
    stall = 1'b1;
    tick();
    check("st_issue", {31'd0, if_Busy}, 32'd1);
    tick();
    check("st_hold_pc",  id_PC, 32'hC);
    check("st_hold_req", {31'd0, imem_req}, 32'd0);
    tick();
    check("st_hold_pc2",  id_PC, 32'hC);
    check("st_hold_req2", {31'd0, imem_req}, 32'd0);
    check("st_hold_busy", {31'd0, if_Busy},  32'd0);
    stall = 1'b0;
    tick();
    check("st_rel_pc",   id_PC,   32'h10);
    check("st_rel_inst", id_Inst, 32'h1234_5678);
    check("st_rel_addr", imem_addr, 32'h14);

    // Branch while WAITing for 0x20, response two cycles after request
    for (int i = 0; i < 6; i++) tick();
    check("br_addr20", imem_addr, 32'h20);
    lat = 2;
    tick();
    br_taken = 1'b1; br_target = 32'h103;
    tick();
    br_taken = 1'b0;
    check("br_valid", {31'd0, id_Valid}, 32'd0);
    check("br_inst",  id_Inst, 32'h0000_0013);
    check("br_drop",  {31'd0, if_Busy}, 32'd1);
    lat = 1;
    tick();
    check("br_req",   {31'd0, imem_req}, 32'd1);
    check("br_addr",  imem_addr, 32'h100);
    check("br_valid2", {31'd0, id_Valid}, 32'd0);
    tick(); tick();
    check("br_idpc",  id_PC,   32'h100);
    check("br_inst2", id_Inst, 32'hC0DE_0100);

    // Branch and stall together in HOLD
    stall = 1'b1;
    tick(); tick();
    br_taken = 1'b1; br_target = 32'h200;
    tick();
    br_taken = 1'b0; stall = 1'b0;
    check("hb_valid", {31'd0, id_Valid}, 32'd0);
    check("hb_inst",  id_Inst, 32'h0000_0013);
    check("hb_req",   {31'd0, imem_req}, 32'd1);
    check("hb_addr",  imem_addr, 32'h200);
    tick(); tick();
    check("hb_idpc", id_PC, 32'h200);

    // PC wrap at the top of the address space
    br_taken = 1'b1; br_target = 32'hFFFF_FFFC;
    tick();
    br_taken = 1'b0;
    check("wr_drop", {31'd0, if_Busy}, 32'd1);
    tick();
    check("wr_addr", imem_addr, 32'hFFFF_FFFC);
    tick(); tick();
    check("wr_idpc", id_PC, 32'hFFFF_FFFC);
    check("wr_next", imem_addr, 32'h0);

    // Reset in WAIT with a response in the same cycle
    tick();
    check("rw_rsp", {31'd0, imem_valid}, 32'd1);
    rst = 1'b1;
    tick();
    check("rw_req",   {31'd0, imem_req}, 32'd0);
    check("rw_valid", {31'd0, id_Valid}, 32'd0);
    rst = 1'b0;
    #1;
    check("rw_req2",  {31'd0, imem_req}, 32'd1);
    check("rw_addr",  imem_addr, 32'h0);
    check("rw_inst",  id_Inst, 32'h0000_0013);
    tick(); tick();
    check("rw_idpc",   id_PC,   32'h0);
    check("rw_inst2",  id_Inst, 32'h00A0_0093);
    check("rw_valid2", {31'd0, id_Valid}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
